// File: rtl/ccff_cfg_pkg.sv
// Shared types and sizing helpers for the ccff configuration loader.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ccff_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Number of host words needed to cover the whole chain (last may be partial).
    function automatic int calc_num_words(input int num_bits, input int word_w);
        return (num_bits + word_w - 1) / word_w;
    endfunction

    // Bit counter width able to hold the value num_bits itself.
    function automatic int calc_cnt_w(input int num_bits);
        return $clog2(num_bits + 1);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Purpose: WORD_W-bit parallel-load shift register feeding the chain MSB-first.
// Latency: load/shift take effect on the next clk; next_msb previews the MSB after that edge.
// Backpressure: none; the owner decides when to load or shift.
// Ports: clk, reset (sync, active-high), load/din (parallel load), shift (left by one),
//        next_msb (MSB the register will hold after the coming edge).
module ccff_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              next_msb
);

    logic [WORD_W-1:0] shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= {shreg[WORD_W-2:0], 1'b0};
        end
    end

    // Lets the top register ccff_head in the same edge that updates shreg,
    // so ccff_head always equals the MSB of the word being shifted.
    always_comb begin
        next_msb = shreg[WORD_W-1];
        if (load) begin
            next_msb = din[WORD_W-1];
        end else if (shift) begin
            next_msb = shreg[WORD_W-2];
        end
    end

endmodule

// File: rtl/ccff_config_loader.sv
// Purpose: streams host configuration words MSB-first into the fabric ccff chain.
// Latency: start -> cfg_ready 1 cycle; handshake -> first prog_clk_en 1 cycle; done 1 cycle after last bit.
// Backpressure: cfg_ready only in WAIT_WORD and on the last bit of a word; a late word
//               just inserts prog_clk_en=0 bubbles, the chain never sees a bogus bit.
// Ports: clk, reset (sync, active-high), start, abort, cfg_data/cfg_valid/cfg_ready,
//        ccff_head and prog_clk_en (registered chain drive), busy, done.
// Optional: define CCFF_PARITY_CHECK_EN to add exp_parity (sampled on start) and parity_err.
module ccff_config_loader
    import ccff_cfg_pkg::*;
#(
    parameter int NUM_BITS = 66,
    parameter int WORD_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              prog_clk_en,
    output logic              busy,
    output logic              done
`ifdef CCFF_PARITY_CHECK_EN
   ,input  logic              exp_parity,
    output logic              parity_err
`endif
);

    localparam int NUM_WORDS = calc_num_words(NUM_BITS, WORD_W);
    localparam int CNT_W     = calc_cnt_w(NUM_BITS);
    localparam int IDX_W     = $clog2(WORD_W);
    localparam int WC_W      = $clog2(NUM_WORDS + 1);

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;   // bits shifted so far in this load
    logic [IDX_W-1:0]   bit_idx;   // position inside the current word
    logic [WC_W-1:0]    word_cnt;  // words accepted so far in this load

    logic last_in_word;
    logic final_bit;
    logic more_words;
    logic hs;
    logic ser_load;
    logic ser_shift;
    logic next_msb;

    always_comb begin
        last_in_word = (bit_idx == IDX_W'(WORD_W - 1));
        final_bit    = (bit_cnt == CNT_W'(NUM_BITS - 1));
        more_words   = (word_cnt < WC_W'(NUM_WORDS));

        // A partial last word never asks for more data: final_bit ends the load
        // before the unused low bits of that word are reached.
        cfg_ready = 1'b0;
        if (!abort) begin
            if (state == WAIT_WORD) begin
                cfg_ready = 1'b1;
            end else if (state == SHIFT && last_in_word && !final_bit && more_words) begin
                cfg_ready = 1'b1;
            end
        end

        hs        = cfg_valid && cfg_ready;
        ser_load  = hs;
        ser_shift = (state == SHIFT) && !abort && !hs;
    end

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .shift    (ser_shift),
        .din      (cfg_data),
        .next_msb (next_msb)
    );

    // prog_clk_en is high exactly in the cycles the FSM sits in SHIFT, with
    // ccff_head carrying that cycle's bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            word_cnt    <= '0;
            ccff_head   <= 1'b0;
            prog_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= WAIT_WORD;
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end

                WAIT_WORD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (hs) begin
                        state       <= SHIFT;
                        bit_idx     <= '0;
                        word_cnt    <= word_cnt + 1'b1;
                        prog_clk_en <= 1'b1;
                        ccff_head   <= next_msb;
                    end
                end

                SHIFT: begin
                    if (abort) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        prog_clk_en <= 1'b0;
                        ccff_head   <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (final_bit) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            prog_clk_en <= 1'b0;
                            ccff_head   <= 1'b0;
                        end else if (last_in_word) begin
                            if (hs) begin
                                // Back-to-back word: no bubble on prog_clk_en.
                                bit_idx   <= '0;
                                word_cnt  <= word_cnt + 1'b1;
                                ccff_head <= next_msb;
                            end else begin
                                state       <= WAIT_WORD;
                                prog_clk_en <= 1'b0;
                                ccff_head   <= 1'b0;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            ccff_head <= next_msb;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CCFF_PARITY_CHECK_EN
    logic par_acc;
    logic exp_par_q;

    // ccff_head holds the bit driven in each SHIFT cycle, so folding it in
    // there covers exactly the bits that saw prog_clk_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_acc    <= 1'b0;
            exp_par_q  <= 1'b0;
            parity_err <= 1'b0;
        end else if ((state == IDLE || state == DONE) && start) begin
            par_acc    <= 1'b0;
            exp_par_q  <= exp_parity;
            parity_err <= 1'b0;
        end else if (state == SHIFT && !abort) begin
            par_acc <= par_acc ^ ccff_head;
            if (final_bit) begin
                parity_err <= (par_acc ^ ccff_head) != exp_par_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ccff_config_loader.sv
// Directed bench for ccff_config_loader (NUM_BITS=66, WORD_W=8).
// Latency: n/a.  Backpressure: host stalls are injected on word 4 in one scenario.
module tb_ccff_config_loader;

    localparam int NB = 66;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [W-1:0] cfg_data;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         ccff_head;
    logic         prog_clk_en;
    logic         busy;
    logic         done;
`ifdef CCFF_PARITY_CHECK_EN
    logic         exp_parity;
    logic         parity_err;
`endif

    ccff_config_loader #(
        .NUM_BITS (NB),
        .WORD_W   (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .ccff_head   (ccff_head),
        .prog_clk_en (prog_clk_en),
        .busy        (busy),
        .done        (done)
`ifdef CCFF_PARITY_CHECK_EN
       ,.exp_parity  (exp_parity),
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [NB-1:0] cap;
    int en_cnt;
    int first_en;
    int last_en;
    int done_cyc;
    int words_sent;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 plain load, 1 abort, 2 reset, 3 start pulse while busy; the event
    // fires in the cycle showing enabled bit number ev_bit.
    task automatic run_load(input logic [W-1:0] word, input int stall_word, input int stall_n,
                            input int mode, input int ev_bit, input bit abort_with_start);
        int stall_left;
        stall_left = stall_n;
        cap        = '0;
        en_cnt     = 0;
        first_en   = -1;
        last_en    = -1;
        done_cyc   = -1;
        words_sent = 0;

        start = 1'b1;
        abort = abort_with_start;
        tick();
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("start_busy", busy, 1);
        check("start_ready_latency", cfg_ready, 1);
        check("start_clears_done", done, 0);

        for (int c = 0; c < 400; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            if (prog_clk_en) begin
                if (en_cnt < NB) cap[en_cnt] = ccff_head;
                if (first_en < 0) first_en = c;
                last_en = c;
                en_cnt++;
            end
            cfg_data  = word;
            cfg_valid = (words_sent < 9);
            start     = 1'b0;
            abort     = 1'b0;
            if (words_sent == stall_word && stall_left > 0 && cfg_ready) begin
                cfg_valid = 1'b0;
                stall_left--;
            end
            if (prog_clk_en && en_cnt == ev_bit) begin
                if (mode == 1) abort = 1'b1;
                else if (mode == 2) reset = 1'b1;
                else if (mode == 3) start = 1'b1;
            end
            #1;
            if (cfg_valid && cfg_ready) words_sent++;
            tick();
            if (abort || reset) begin
                abort     = 1'b0;
                reset     = 1'b0;
                cfg_valid = 1'b0;
                #1;
                check("evt_prog_clk_en", prog_clk_en, 0);
                check("evt_busy", busy, 0);
                check("evt_done", done, 0);
                check("evt_cfg_ready", cfg_ready, 0);
                check("evt_ccff_head", ccff_head, 0);
                return;
            end
        end
        cfg_valid = 1'b0;
        check("load_done_seen", (done_cyc >= 0), 1);
    endtask

    task automatic check_complete(input int exp_bubbles, input logic [W-1:0] word);
        logic [NB-1:0] exp_vec;
        for (int i = 0; i < NB; i++) exp_vec[i] = word[W-1-(i%W)];
        check("bit_count", en_cnt, NB);
        check("bubbles", (last_en - first_en + 1) - en_cnt, exp_bubbles);
        check("done_latency", done_cyc, last_en + 1);
        check("done_level", done, 1);
        check("busy_after", busy, 0);
        check("ready_in_done", cfg_ready, 0);
        check("bit_pattern", cap, exp_vec);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
`ifdef CCFF_PARITY_CHECK_EN
        exp_parity = 1'b0;
`endif
        repeat (3) tick();
        check("rst_head", ccff_head, 0);
        check("rst_en", prog_clk_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cfg_ready, 0);
        reset = 1'b0;
        tick();
        check("idle_ready", cfg_ready, 0);

        // Basic back-to-back load of 0xA5.
        run_load(8'hA5, -1, 0, 0, -1, 1'b0);
        check_complete(0, 8'hA5);
        tick();
        check("done_holds", done, 1);
        check("done_en_low", prog_clk_en, 0);

        // abort while DONE does nothing.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_in_done_done", done, 1);
        check("abort_in_done_busy", busy, 0);

        // Host stalls 3 cycles before word 4; start+abort in DONE: start wins.
        run_load(8'hA5, 3, 3, 0, -1, 1'b1);
        check_complete(3, 8'hA5);

        // Abort at bit 20, then a fresh full load.
        run_load(8'h3C, -1, 0, 1, 20, 1'b0);
        check("abort_bits", en_cnt, 20);
        tick();
        check("abort_idle_en", prog_clk_en, 0);
        check("abort_idle_busy", busy, 0);
        run_load(8'h3C, -1, 0, 0, -1, 1'b0);
        check_complete(0, 8'h3C);

        // Reset mid-shift at bit 40.
        run_load(8'hA5, -1, 0, 2, 40, 1'b0);
        check("reset_bits", en_cnt, 40);
        tick();
        check("reset_idle_ready", cfg_ready, 0);
        check("reset_idle_en", prog_clk_en, 0);

        // start pulse at bit 10 is ignored.
        run_load(8'h5A, -1, 0, 3, 10, 1'b0);
        check_complete(0, 8'h5A);

`ifdef CCFF_PARITY_CHECK_EN
        exp_parity = 1'b0;
        run_load(8'hFF, -1, 0, 0, -1, 1'b0);
        check_complete(0, 8'hFF);
        check("parity_ok", parity_err, 0);
        exp_parity = 1'b1;
        run_load(8'hFF, -1, 0, 0, -1, 1'b0);
        check_complete(0, 8'hFF);
        check("parity_bad", parity_err, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
